// File: rtl/radar_pulse_sequencer.sv
// radar_pulse_sequencer: frame sequencer for the FMC150 chirp/ADC datapath.
// Runs the chirp generator init/ready handshake, fires pulse_count chirps at a
// latched PRI and gates the ADC capture window inside every pulse.
module radar_pulse_sequencer #(
    parameter int CNT_WIDTH     = 32,
    parameter int READY_TIMEOUT = 1_000_000,
    parameter int MIN_PRI       = 4
) (
    input  logic                 clk_245_76MHz,
    input  logic                 clk_245_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] pulse_count,
    input  logic [CNT_WIDTH-1:0] pri_cycles,
    input  logic [CNT_WIDTH-1:0] adc_delay,
    input  logic [CNT_WIDTH-1:0] adc_len,
    input  logic                 chirp_ready,
    input  logic                 chirp_done,
    output logic                 chirp_init,
    output logic                 chirp_enable,
    output logic                 adc_enable,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 aborted,
    output logic                 ready_timeout_err,
    output logic [CNT_WIDTH-1:0] pulse_index,
    output logic [CNT_WIDTH-1:0] chirp_done_count
);

    typedef enum logic [2:0] {IDLE, INIT, WAIT_RDY, FIRE, RUN, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(READY_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_PRI_W    = CNT_WIDTH'(MIN_PRI);
    localparam logic [CNT_WIDTH-1:0] ONE          = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   TWO_WIDE     = (CNT_WIDTH+1)'(2);

    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] cfg_count;
    logic [CNT_WIDTH-1:0] cfg_pri;
    logic [CNT_WIDTH-1:0] cfg_delay;
    logic [CNT_WIDTH-1:0] cfg_len;
    logic [CNT_WIDTH-1:0] offset;
    logic [CNT_WIDTH-1:0] next_offset;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [CNT_WIDTH-1:0] next_wait_cnt;
    logic [CNT_WIDTH-1:0] next_pulse_index;
    logic [CNT_WIDTH:0]   win_sum;
    logic [CNT_WIDTH:0]   win_limit;
    logic [CNT_WIDTH:0]   win_end;
    logic                 latch_cfg;
    logic                 empty_start;
    logic                 timeout_hit;
    logic                 next_adc;
    logic                 done_q;

    // Window end = min(delay+len, PRI-2), one bit wider so the sum never wraps.
    always_comb begin
        win_sum   = {1'b0, cfg_delay} + {1'b0, cfg_len};
        win_limit = {1'b0, cfg_pri} - TWO_WIDE;
        win_end   = (win_sum < win_limit) ? win_sum : win_limit;
    end

    // Next-state logic; abort overrides every transition including start.
    always_comb begin
        next_state       = state;
        next_offset      = offset;
        next_wait_cnt    = wait_cnt;
        next_pulse_index = pulse_index;
        latch_cfg        = 1'b0;
        empty_start      = 1'b0;
        timeout_hit      = 1'b0;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (pulse_count == '0) begin
                            empty_start = 1'b1;
                        end else begin
                            latch_cfg        = 1'b1;
                            next_pulse_index = '0;
                            next_state       = INIT;
                        end
                    end
                end
                INIT: begin
                    next_wait_cnt = '0;
                    next_state    = WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (chirp_ready) begin
                        next_offset = '0;
                        next_state  = FIRE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        timeout_hit = 1'b1;
                        next_state  = IDLE;
                    end else begin
                        next_wait_cnt = wait_cnt + ONE;
                    end
                end
                FIRE: begin
                    next_offset = offset + ONE;
                    next_state  = RUN;
                end
                RUN: begin
                    if (offset == cfg_pri - ONE) begin
                        if (pulse_index == cfg_count - ONE) begin
                            next_state = DONE;
                        end else begin
                            next_pulse_index = pulse_index + ONE;
                            next_offset      = '0;
                            next_state       = FIRE;
                        end
                    end else begin
                        next_offset = offset + ONE;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
        next_adc = ((next_state == FIRE) || (next_state == RUN))
                   && (next_offset >= cfg_delay)
                   && ({1'b0, next_offset} < win_end);
    end

    // State register plus the offset/timeout counters and latched frame config.
    always_ff @(posedge clk_245_76MHz) begin
        if (clk_245_rst) begin
            state     <= IDLE;
            offset    <= '0;
            wait_cnt  <= '0;
            cfg_count <= '0;
            cfg_pri   <= '0;
            cfg_delay <= '0;
            cfg_len   <= '0;
        end else begin
            state    <= next_state;
            offset   <= next_offset;
            wait_cnt <= next_wait_cnt;
            if (latch_cfg) begin
                cfg_count <= pulse_count;
                cfg_pri   <= (pri_cycles < MIN_PRI_W) ? MIN_PRI_W : pri_cycles;
                cfg_delay <= adc_delay;
                cfg_len   <= adc_len;
            end
        end
    end

    // Registered outputs, all derived from the state being entered next cycle.
    always_ff @(posedge clk_245_76MHz) begin
        if (clk_245_rst) begin
            chirp_init        <= 1'b0;
            chirp_enable      <= 1'b0;
            adc_enable        <= 1'b0;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
            aborted           <= 1'b0;
            ready_timeout_err <= 1'b0;
            pulse_index       <= '0;
            chirp_done_count  <= '0;
            done_q            <= 1'b0;
        end else begin
            chirp_init   <= (next_state == INIT);
            chirp_enable <= (next_state == FIRE);
            adc_enable   <= next_adc;
            busy         <= (next_state != IDLE);
            frame_done   <= (next_state == DONE) || empty_start;
            aborted      <= abort && busy;
            pulse_index  <= next_pulse_index;
            done_q       <= chirp_done;
            if (timeout_hit) begin
                ready_timeout_err <= 1'b1;
            end else if (latch_cfg) begin
                ready_timeout_err <= 1'b0;
            end
            if (latch_cfg) begin
                chirp_done_count <= '0;
            end else if (busy && chirp_done && !done_q) begin
                chirp_done_count <= chirp_done_count + ONE;
            end
        end
    end

endmodule

// File: tb/tb_radar_pulse_sequencer.sv
// tb_radar_pulse_sequencer: randomized frames checked cycle by cycle against a
// timeline model built from the frame rules (fire times, window, done time).
`timescale 1ns/1ps
module tb_radar_pulse_sequencer;

    localparam int W    = 32;
    localparam int RT   = 16;
    localparam int MINP = 4;

    logic          clk_245_76MHz = 1'b0;
    logic          clk_245_rst;
    logic          start;
    logic          abort;
    logic [W-1:0]  pulse_count;
    logic [W-1:0]  pri_cycles;
    logic [W-1:0]  adc_delay;
    logic [W-1:0]  adc_len;
    logic          chirp_ready;
    logic          chirp_done;
    logic          chirp_init;
    logic          chirp_enable;
    logic          adc_enable;
    logic          busy;
    logic          frame_done;
    logic          aborted;
    logic          ready_timeout_err;
    logic [W-1:0]  pulse_index;
    logic [W-1:0]  chirp_done_count;

    int   checks_total  = 0;
    int   checks_passed = 0;
    int   cyc           = 0;

    int   f_n, f_pri, f_d, f_l, f_rd, f_abort, f_rst;
    int   m_index;
    int   m_count;
    logic m_err;

    // 245.76 MHz-ish clock; exact period is irrelevant to the checks
    always #2 clk_245_76MHz = ~clk_245_76MHz;

    radar_pulse_sequencer #(
        .CNT_WIDTH     (W),
        .READY_TIMEOUT (RT),
        .MIN_PRI       (MINP)
    ) dut (
        .clk_245_76MHz     (clk_245_76MHz),
        .clk_245_rst       (clk_245_rst),
        .start             (start),
        .abort             (abort),
        .pulse_count       (pulse_count),
        .pri_cycles        (pri_cycles),
        .adc_delay         (adc_delay),
        .adc_len           (adc_len),
        .chirp_ready       (chirp_ready),
        .chirp_done        (chirp_done),
        .chirp_init        (chirp_init),
        .chirp_enable      (chirp_enable),
        .adc_enable        (adc_enable),
        .busy              (busy),
        .frame_done        (frame_done),
        .aborted           (aborted),
        .ready_timeout_err (ready_timeout_err),
        .pulse_index       (pulse_index),
        .chirp_done_count  (chirp_done_count)
    );

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] exp_val);
        checks_total++;
        if (observed === exp_val) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, observed, exp_val);
        end
    endtask

    // Expected outputs for frame cycle c (c=0 is the cycle after start is sampled), ignoring abort/reset
    function automatic void base_expect(input int c, output logic e_busy, output logic e_init,
                                        output logic e_en, output logic e_adc, output logic e_done,
                                        output logic e_err, output int e_idx);
        int  fire, last_busy, off, p, wend;
        bit  timed_out;
        timed_out = (f_rd > RT - 1);
        fire      = f_rd + 2;
        e_en      = 1'b0;
        e_adc     = 1'b0;
        if (f_n == 0) begin
            e_busy = 1'b0;
            e_init = 1'b0;
            e_done = (c == 0);
            e_err  = m_err;
            e_idx  = m_index;
        end else begin
            last_busy = timed_out ? RT : fire + f_n * f_pri;
            e_busy    = (c <= last_busy);
            e_init    = (c == 0);
            e_done    = !timed_out && (c == last_busy);
            e_err     = timed_out && (c > RT);
            e_idx     = 0;
            if (!timed_out && c >= fire) begin
                off  = (c - fire) % f_pri;
                p    = (c - fire) / f_pri;
                wend = f_d + f_l;
                if (wend > f_pri - 2) wend = f_pri - 2;
                if (p < f_n) begin
                    e_en  = (off == 0);
                    e_adc = (off >= f_d) && (off < wend);
                end
                e_idx = (p < f_n) ? p : f_n - 1;
            end
        end
    endfunction

    // Expected outputs including the effect of a planned abort or reset
    function automatic void full_expect(input int c, output logic e_busy, output logic e_init,
                                        output logic e_en, output logic e_adc, output logic e_done,
                                        output logic e_err, output int e_idx, output logic e_abt);
        logic b_busy, b_init, b_en, b_adc, b_done, b_err;
        int   b_idx;
        e_abt = 1'b0;
        if (f_rst >= 0 && c > f_rst) begin
            e_busy = 1'b0; e_init = 1'b0; e_en = 1'b0; e_adc = 1'b0;
            e_done = 1'b0; e_err = 1'b0; e_idx = 0;
        end else if (f_abort >= 0 && c > f_abort) begin
            base_expect(f_abort, b_busy, b_init, b_en, b_adc, b_done, b_err, b_idx);
            e_busy = 1'b0; e_init = 1'b0; e_en = 1'b0; e_adc = 1'b0; e_done = 1'b0;
            e_err  = b_err;
            e_idx  = b_idx;
            e_abt  = (c == f_abort + 1) && b_busy;
        end else begin
            base_expect(c, e_busy, e_init, e_en, e_adc, e_done, e_err, e_idx);
        end
    endfunction

    // Run one frame: start, then per cycle check outputs and drive ready/done/abort/reset and config noise
    task automatic applyStimulus(input int n, input int pri_raw, input int d, input int l,
                                 input int rd, input int ab, input int rs);
        logic eb, ei, ee, ea, ed, er, eab, cd, prev_cd;
        int   eidx, cnt, last, lb;
        f_n = n; f_pri = (pri_raw < MINP) ? MINP : pri_raw;
        f_d = d; f_l = l; f_rd = rd; f_abort = ab; f_rst = rs;
        lb   = (n == 0) ? 0 : ((rd > RT - 1) ? RT : rd + 2 + n * f_pri);
        last = (ab >= 0) ? ab + 3 : ((rs >= 0) ? rs + 3 : lb + 3);
        @(negedge clk_245_76MHz);
        start       = 1'b1;
        abort       = 1'b0;
        pulse_count = n;
        pri_cycles  = pri_raw;
        adc_delay   = d;
        adc_len     = l;
        chirp_ready = 1'b0;
        chirp_done  = 1'b0;
        prev_cd     = 1'b0;
        cnt         = (n > 0) ? 0 : m_count;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk_245_76MHz);
            cyc = c;
            full_expect(c, eb, ei, ee, ea, ed, er, eidx, eab);
            checkOutput("busy",         32'(busy),              32'(eb));
            checkOutput("chirp_init",   32'(chirp_init),        32'(ei));
            checkOutput("chirp_enable", 32'(chirp_enable),      32'(ee));
            checkOutput("adc_enable",   32'(adc_enable),        32'(ea));
            checkOutput("frame_done",   32'(frame_done),        32'(ed));
            checkOutput("aborted",      32'(aborted),           32'(eab));
            checkOutput("timeout_err",  32'(ready_timeout_err), 32'(er));
            checkOutput("pulse_index",  pulse_index,            32'(eidx));
            checkOutput("done_count",   chirp_done_count,       32'(cnt));
            start       = 1'b0;
            pulse_count = $urandom;
            pri_cycles  = $urandom_range(1, 40);
            adc_delay   = $urandom;
            adc_len     = $urandom;
            chirp_ready = (c >= rd + 1);
            abort       = (c == ab);
            clk_245_rst = (c == rs);
            cd          = ($urandom_range(0, 1) != 0);
            chirp_done  = cd;
            if (c == rs) cnt = 0;
            else if (eb && cd && !prev_cd) cnt++;
            prev_cd = cd;
            m_index = eidx;
            m_err   = er;
        end
        m_count     = cnt;
        chirp_done  = 1'b0;
        chirp_ready = 1'b0;
        abort       = 1'b0;
        clk_245_rst = 1'b0;
    endtask

    initial begin
        clk_245_rst = 1'b1;
        start = 1'b0; abort = 1'b0; chirp_ready = 1'b0; chirp_done = 1'b0;
        pulse_count = '0; pri_cycles = '0; adc_delay = '0; adc_len = '0;
        m_index = 0; m_count = 0; m_err = 1'b0;
        @(negedge clk_245_76MHz);
        @(negedge clk_245_76MHz);
        checkOutput("rst_busy",       32'(busy),              32'd0);
        checkOutput("rst_frame_done", 32'(frame_done),        32'd0);
        checkOutput("rst_adc",        32'(adc_enable),        32'd0);
        checkOutput("rst_err",        32'(ready_timeout_err), 32'd0);
        checkOutput("rst_index",      pulse_index,            32'd0);
        clk_245_rst = 1'b0;

        applyStimulus(3, 20, 5, 8, 0, -1, -1);
        applyStimulus(2, 10, 2, 100, 0, -1, -1);
        applyStimulus(0, 20, 5, 8, 0, -1, -1);
        applyStimulus(3, 1, 0, 1, 0, -1, -1);
        applyStimulus(2, 20, 5, 8, 30, -1, -1);
        applyStimulus(1, 12, 3, 4, 2, -1, -1);
        applyStimulus(3, 20, 5, 8, 0, 29, -1);
        applyStimulus(3, 20, 5, 8, 0, -1, 30);

        // start and abort together in IDLE: abort wins, nothing happens
        @(negedge clk_245_76MHz);
        start = 1'b1; abort = 1'b1; pulse_count = 3; pri_cycles = 20;
        @(negedge clk_245_76MHz);
        checkOutput("idle_abort_busy",    32'(busy),       32'd0);
        checkOutput("idle_abort_init",    32'(chirp_init), 32'd0);
        checkOutput("idle_abort_aborted", 32'(aborted),    32'd0);
        start = 1'b0; abort = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int n, pr, d, l, rd, ab, rs, ep, lb;
            n  = $urandom_range(0, 4);
            if (n == 0 && m_err) n = 1;
            pr = $urandom_range(1, 30);
            ep = (pr < MINP) ? MINP : pr;
            d  = $urandom_range(0, ep + 2);
            l  = ($urandom_range(0, 7) == 0) ? 100000 : $urandom_range(0, ep);
            rd = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
            lb = (n == 0) ? 0 : ((rd > RT - 1) ? RT : rd + 2 + n * ep);
            ab = -1;
            rs = -1;
            if (n > 0) begin
                if ($urandom_range(0, 5) == 0) ab = $urandom_range(0, lb);
                else if ($urandom_range(0, 11) == 0) rs = $urandom_range(0, lb);
            end
            applyStimulus(n, pr, d, l, rd, ab, rs);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
